// File: rtl/wallece_tree_mult_pipe.sv
// wallece_tree_mult_pipe
//   Pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, three register
//   stages (partial products, carry-save reduction, final add). Valid/ready
//   handshakes on both sides. Bubbles collapse, and a full pipeline can take
//   a new operand in the same cycle that a result leaves.
//
//   Optional feature macro: WALLECE_SIGNED_EN
//     defined   : per-transaction two's-complement mode (Baugh-Wooley) via Signed.
//     undefined : Signed is ignored and every product is unsigned.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears control and datapath)
//   in_valid   in   operand transfer request
//   in_ready   out  operands accepted this cycle (combinational from out_ready)
//   A, B       in   WIDTH-bit operands
//   Signed     in   1 = A/B/Prod are two's complement, sampled with A/B
//   out_valid  out  Prod holds a valid result
//   out_ready  in   consumer accepts Prod this cycle
//   Prod       out  2*WIDTH-bit product, held until replaced
module wallece_tree_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Prod
);

  localparam int PW = 2 * WIDTH;
  // WIDTH partial-product rows plus one row holding the signed-mode correction.
  localparam int NR = WIDTH + 1;
  // Enough 3:2 levels to bring up to 33 rows down to 2; spare levels pass through.
  localparam int LV = 8;
  // Baugh-Wooley correction: +2^WIDTH and +2^(2*WIDTH-1).
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // Row count after lv levels of full-adder compression (groups of three rows
  // become a sum row and a carry row; the remainder passes through).
  function automatic int rows_at(input int lv);
    int n;
    n = NR;
    for (int i = 0; i < lv; i++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // One row of AND terms (A * B[i]). In signed mode the cross terms that pair
  // exactly one operand MSB with a non-MSB bit are inverted.
  function automatic logic [WIDTH-1:0] pp_row(input logic [WIDTH-1:0] a,
                                              input logic             b_bit,
                                              input logic             msb_row,
                                              input logic             sgn);
    logic [WIDTH-1:0] r;
    r = a & {WIDTH{b_bit}};
    if (sgn) begin
      if (msb_row) begin
        r[WIDTH-2:0] = ~r[WIDTH-2:0];
      end else begin
        r[WIDTH-1] = ~r[WIDTH-1];
      end
    end
    return r;
  endfunction

  logic             adv1, adv2, adv3;
  logic             in_fire;
  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic             vld_p3_q, vld_p3_d;
  logic [WIDTH-1:0] pp_p1_q [WIDTH];
  logic [WIDTH-1:0] pp_p1_d [WIDTH];
  logic [PW-1:0]    sum_p2_q, sum_p2_d;
  logic [PW-1:0]    car_p2_q, car_p2_d;
  logic [PW-1:0]    prod_p3_q, prod_p3_d;
  logic             sgn_in;
  logic             sgn_s2;
  logic [PW-1:0]    lvl [LV+1][NR];

  // Each stage moves when it is empty or its downstream moves.
  always_comb begin
    adv3     = !vld_p3_q || out_ready;
    adv2     = !vld_p2_q || adv3;
    adv1     = !vld_p1_q || adv2;
    in_ready = adv1 && rst_n;
    in_fire  = in_valid && in_ready;
  end

`ifdef WALLECE_SIGNED_EN
  logic sgn_p1_q, sgn_p1_d;

  assign sgn_in = Signed;
  assign sgn_s2 = sgn_p1_q;

  always_comb begin
    sgn_p1_d = sgn_p1_q;
    if (in_fire) begin
      sgn_p1_d = Signed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_p1_q <= 1'b0;
    end else begin
      sgn_p1_q <= sgn_p1_d;
    end
  end
`else
  logic signed_unused;

  assign signed_unused = Signed;
  assign sgn_in        = 1'b0;
  assign sgn_s2        = 1'b0;
`endif

  // ---- stage 1: partial products ----
  always_comb begin
    vld_p1_d = adv1 ? in_valid : vld_p1_q;
    pp_p1_d  = pp_p1_q;
    if (in_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        pp_p1_d[i] = pp_row(A, B[i], i == WIDTH - 1, sgn_in);
      end
    end
  end

  // ---- stage 2: Wallace reduction to sum/carry rows ----
  for (genvar r = 0; r < WIDTH; r++) begin : g_row0
    assign lvl[0][r] = PW'(pp_p1_q[r]) << r;
  end
  assign lvl[0][WIDTH] = sgn_s2 ? BW_CORR : '0;

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int N  = rows_at(l);
    localparam int NF = N / 3;
    localparam int NN = rows_at(l + 1);
    for (genvar g = 0; g < NF; g++) begin : g_fa
      assign lvl[l+1][2*g]   = lvl[l][3*g] ^ lvl[l][3*g+1] ^ lvl[l][3*g+2];
      // Carries shift up one column; the bit leaving the top is dropped (mod 2^PW).
      assign lvl[l+1][2*g+1] = ((lvl[l][3*g]   & lvl[l][3*g+1]) |
                                (lvl[l][3*g]   & lvl[l][3*g+2]) |
                                (lvl[l][3*g+1] & lvl[l][3*g+2])) << 1;
    end
    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign lvl[l+1][2*NF+r] = lvl[l][3*NF+r];
    end
    for (genvar r = NN; r < NR; r++) begin : g_zero
      assign lvl[l+1][r] = '0;
    end
  end

  always_comb begin
    vld_p2_d = adv2 ? vld_p1_q : vld_p2_q;
    sum_p2_d = sum_p2_q;
    car_p2_d = car_p2_q;
    if (adv2 && vld_p1_q) begin
      sum_p2_d = lvl[LV][0];
      car_p2_d = lvl[LV][1];
    end
  end

  // ---- stage 3: carry-propagate add ----
  always_comb begin
    vld_p3_d  = adv3 ? vld_p2_q : vld_p3_q;
    prod_p3_d = prod_p3_q;
    if (adv3 && vld_p2_q) begin
      prod_p3_d = sum_p2_q + car_p2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        pp_p1_q[i] <= '0;
      end
      sum_p2_q  <= '0;
      car_p2_q  <= '0;
      prod_p3_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      pp_p1_q   <= pp_p1_d;
      sum_p2_q  <= sum_p2_d;
      car_p2_q  <= car_p2_d;
      prod_p3_q <= prod_p3_d;
    end
  end

  assign out_valid = vld_p3_q;
  assign Prod      = prod_p3_q;

endmodule
